ddr2_imem_loader: RTL and testbench

Hardware block mover between the DDR2 read path and the instruction memory write port. It replaces the CPU's word-by-word MMIO copy loop, which sets the DDR2 read address, the read-divide address, the IMEM address and the IMEM control registers for every word. Given a DDR2 source line address, an IMEM destination word address and a word count, it does three things:
- issues DDR2 line reads;
- splits each 128-bit line into 32-bit words;
- writes the words into IMEM, one per cycle.

The CPU starts it through MMIO registers and polls busy/done/err.

---
 rtl/ddr2_imem_loader.sv | 193 +++++++++++++++++++
 tb/tb_ddr2_imem_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_imem_loader.sv
// DDR2-to-IMEM block mover: fetches 128-bit lines and writes them as 32-bit words.
// Define LOADER_CHECKSUM_EN to add a running 32-bit sum of written words.
module ddr2_imem_loader #(
    parameter int IMEM_AW   = 12,
    parameter int DDR_AW    = 24,
    parameter int LINE_STEP = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DDR_AW-1:0]  src_addr,
    input  logic [IMEM_AW-1:0] dst_addr,
    input  logic [15:0]        num_words,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ddr_re,
    output logic [DDR_AW-1:0]  ddr_addr,
    input  logic [127:0]       ddr_rdata,
    input  logic               ddr_rend,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_a,
    output logic [31:0]        imem_d
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]        checksum
`endif
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REL,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DDR_AW-1:0]  line_addr;
    logic [IMEM_AW-1:0] word_addr;
    logic [15:0]        remaining;
    logic [1:0]         word_idx;
    logic [127:0]       line_buf;
    logic [CW-1:0]      wait_cnt;
    logic               err_q;
    logic               accept;
    logic               wait_hit;
    logic               timeout;
    logic               last_word;

    assign accept    = (state == S_IDLE) && start;
    assign wait_hit  = (wait_cnt == WAIT_MAX);
    assign last_word = (remaining == 16'd1);
    // Timeout only counts while the awaited rend level is still absent.
    assign timeout   = wait_hit &&
                       (((state == S_REQ) && !ddr_rend) ||
                        ((state == S_REL) && ddr_rend));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (num_words == 16'd0) ? S_FINISH : S_REQ;
                end
            end
            S_REQ: begin
                if (ddr_rend) begin
                    state_nx = S_REL;
                end else if (timeout) begin
                    state_nx = S_IDLE;
                end
            end
            S_REL: begin
                if (!ddr_rend) begin
                    state_nx = S_WRITE;
                end else if (timeout) begin
                    state_nx = S_IDLE;
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_nx = S_FINISH;
                end else if (word_idx == 2'd3) begin
                    state_nx = S_REQ;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_addr <= '0;
            word_addr <= '0;
            remaining <= '0;
            word_idx  <= '0;
            line_buf  <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                line_addr <= src_addr;
                word_addr <= dst_addr;
                remaining <= num_words;
                word_idx  <= '0;
                err_q     <= 1'b0;
            end
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if ((state == S_REQ) || (state == S_REL)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if ((state == S_REQ) && ddr_rend) begin
                line_buf <= ddr_rdata;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (state == S_WRITE) begin
                word_addr <= word_addr + IMEM_AW'(1);
                remaining <= remaining - 16'd1;
                word_idx  <= word_idx + 2'd1;
                if ((word_idx == 2'd3) && !last_word) begin
                    line_addr <= line_addr + DDR_AW'(LINE_STEP);
                end
            end
        end
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        ddr_re  = 1'b0;
        imem_we = 1'b0;
        unique case (state)
            S_REQ: begin
                busy   = 1'b1;
                ddr_re = 1'b1;
            end
            S_REL: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
            end
            S_FINISH: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err      = err_q;
    assign ddr_addr = line_addr;
    assign imem_a   = word_addr;
    assign imem_d   = line_buf[{word_idx, 5'd0} +: 32];

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (state == S_WRITE) begin
            sum <= sum + imem_d;
        end
    end

    assign checksum = sum;
`endif

endmodule

// File: tb/tb_ddr2_imem_loader.sv
// Randomized bench for ddr2_imem_loader with a DDR2 responder and a
// transfer-level reference model (line fetches, word order, address wrap).
module tb_ddr2_imem_loader;

    localparam int TMO = 4096;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [23:0]  src_addr;
    logic [11:0]  dst_addr;
    logic [15:0]  num_words;
    logic         busy;
    logic         done;
    logic         err;
    logic         ddr_re;
    logic [23:0]  ddr_addr;
    logic [127:0] ddr_rdata;
    logic         ddr_rend;
    logic         imem_we;
    logic [11:0]  imem_a;
    logic [31:0]  imem_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]  checksum;
`endif

    ddr2_imem_loader dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ddr_re    (ddr_re),
        .ddr_addr  (ddr_addr),
        .ddr_rdata (ddr_rdata),
        .ddr_rend  (ddr_rend),
        .imem_we   (imem_we),
        .imem_a    (imem_a),
        .imem_d    (imem_d)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        logic [31:0] d;
    } wr_t;

    int           n_chk = 0;
    int           n_pass = 0;
    wr_t          wr_q[$];
    int           req_log[$];
    int           done_cnt = 0;
    int           re_rises = 0;
    logic [127:0] ddr_mem[int];

    int           delay;
    int           hold;
    bit           dead;
    bit           fixed_en;
    int           fixed_addr;
    logic [127:0] fixed_data;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_word(input int src, input int i);
        int           a;
        logic [127:0] l;
        a = (src + 8 * (i / 4)) & 'hFFFFFF;
        if (!ddr_mem.exists(a)) return 32'h0;
        l = ddr_mem[a];
        return l[32 * (i % 4) +: 32];
    endfunction

    // DDR2 responder: rend rises `delay` cycles into a request, falls `hold`
    // cycles after re drops; data is garbage outside the valid window.
    initial begin
        int cnt;
        int hcnt;
        int a;
        cnt = 0;
        hcnt = 0;
        ddr_rend = 1'b0;
        ddr_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ddr_rend = 1'b0;
                cnt = 0;
                hcnt = 0;
            end else if (!ddr_rend) begin
                if (ddr_re && !dead) begin
                    cnt++;
                    if (cnt >= delay) begin
                        a = int'(ddr_addr);
                        if (fixed_en && a == fixed_addr)
                            ddr_mem[a] = fixed_data;
                        else if (!ddr_mem.exists(a))
                            ddr_mem[a] = {$urandom, $urandom, $urandom, $urandom};
                        ddr_rdata = ddr_mem[a];
                        ddr_rend = 1'b1;
                        cnt = 0;
                        req_log.push_back(a);
                    end
                end
            end else if (!ddr_re) begin
                if (hcnt >= hold) begin
                    ddr_rend = 1'b0;
                    hcnt = 0;
                    ddr_rdata = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    hcnt++;
                end
            end
        end
    end

    initial begin
        bit re_prev;
        re_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_we) wr_q.push_back('{int'(imem_a), imem_d});
            if (done) done_cnt++;
            if (ddr_re && !re_prev) re_rises++;
            re_prev = ddr_re;
        end
    end

    task automatic run(input string tag, input int src, input int dst,
                       input int num, input bit inject, input bit expect_err);
        int          wb, rb, db, eb, lines, lat, bound;
        bit          got_done, got_err;
        logic [31:0] sum;
        wb = wr_q.size();
        rb = req_log.size();
        db = done_cnt;
        eb = re_rises;
        lines = (num + 3) / 4;
        bound = expect_err ? TMO + 50 : 60 + 40 * lines;
        @(negedge clk);
        src_addr = 24'(src);
        dst_addr = 12'(dst);
        num_words = 16'(num);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk({tag, "_re1"}, ddr_re, num != 0);
        chk({tag, "_err1"}, err, 0);
        got_done = done;
        got_err = err;
        if (done) chk({tag, "_busy_done"}, busy, 0);
        if (inject) begin
            src_addr = $urandom;
            dst_addr = $urandom;
            num_words = 16'(num + 7);
            start = 1'b1;
        end
        while (!(got_done || got_err) && lat < bound) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin
                got_done = 1'b1;
                chk({tag, "_busy_done"}, busy, 0);
            end
            if (err) got_err = 1'b1;
        end
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, "_done"}, got_done, !expect_err);
        chk({tag, "_errflag"}, got_err, expect_err);
        chk({tag, "_ndone"}, done_cnt - db, expect_err ? 0 : 1);
        chk({tag, "_nreq"}, re_rises - eb, expect_err ? 1 : lines);
        chk({tag, "_nwr"}, wr_q.size() - wb, expect_err ? 0 : num);
        chk({tag, "_idle"}, busy, 0);
        if (expect_err) begin
            chk({tag, "_tmo_lat"}, (lat >= TMO && lat <= TMO + 2), 1);
            chk({tag, "_err_sticky"}, err, 1);
            chk({tag, "_re_low"}, ddr_re, 0);
        end
        if (num == 0) chk({tag, "_zero_lat"}, lat <= 2, 1);
        sum = '0;
        if (!expect_err) begin
            for (int i = 0; i < lines && rb + i < req_log.size(); i++)
                chk($sformatf("%s_line%0d", tag, i), req_log[rb + i],
                    (src + 8 * i) & 'hFFFFFF);
            for (int i = 0; i < num && wb + i < wr_q.size(); i++) begin
                chk($sformatf("%s_a%0d", tag, i), wr_q[wb + i].a,
                    (dst + i) & 'hFFF);
                chk($sformatf("%s_d%0d", tag, i), wr_q[wb + i].d,
                    exp_word(src, i));
                sum = sum + exp_word(src, i);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_csum"}, checksum, sum);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wb;
        int db;
        int cnt;
        rst_n = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        num_words = '0;
        delay = 3;
        hold = 1;
        dead = 1'b0;
        fixed_en = 1'b0;
        fixed_addr = 0;
        fixed_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_re", ddr_re, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_ddr_addr", ddr_addr, 0);
        chk("rst_imem_a", imem_a, 0);
        chk("rst_imem_d", imem_d, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_csum", checksum, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        fixed_en = 1'b1;
        fixed_addr = 'h100;
        fixed_data = 128'h44444444_33333333_22222222_11111111;
        delay = 5;
        wb = wr_q.size();
        run("t1", 'h100, 'h010, 4, 1'b1, 1'b0);
        fixed_en = 1'b0;
        for (int i = 0; i < 4 && wb + i < wr_q.size(); i++)
            chk($sformatf("t1_const%0d", i), wr_q[wb + i].d,
                32'h11111111 * (i + 1));
`ifdef LOADER_CHECKSUM_EN
        chk("t1_csum_const", checksum, 32'hAAAAAAAA);
`endif

        delay = 3;
        run("t2", 'h000000, 'h200, 6, 1'b1, 1'b0);
        run("t3", 'h000040, 'h100, 0, 1'b1, 1'b0);
        run("t4", 'h000080, 'hFFE, 4, 1'b0, 1'b0);
        run("t4s", 'hFFFFF8, 'h050, 9, 1'b0, 1'b0);

        dead = 1'b1;
        run("t5", 'h000200, 'h400, 4, 1'b1, 1'b1);
        dead = 1'b0;
        run("t5r", 'h000200, 'h400, 5, 1'b0, 1'b0);

        delay = 2;
        hold = 1;
        wb = wr_q.size();
        db = done_cnt;
        @(negedge clk);
        src_addr = 24'h000400;
        dst_addr = 12'h300;
        num_words = 16'd10;
        start = 1'b1;
        @(negedge clk);
        src_addr = 24'h000800;
        dst_addr = 12'h700;
        num_words = 16'd1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (wr_q.size() - wb < 2 && cnt < 200) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("t6_reach", cnt < 200, 1);
        @(posedge clk);
        #1;
        chk("t6_mid_we", imem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_re", ddr_re, 0);
        chk("t6_we", imem_we, 0);
        chk("t6_imem_a", imem_a, 0);
        chk("t6_imem_d", imem_d, 0);
        chk("t6_ddr_addr", ddr_addr, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_nwr", wr_q.size() - wb, 2);
        for (int i = 0; i < 2 && wb + i < wr_q.size(); i++) begin
            chk($sformatf("t6_a%0d", i), wr_q[wb + i].a, 'h300 + i);
            chk($sformatf("t6_d%0d", i), wr_q[wb + i].d, exp_word('h400, i));
        end
        chk("t6_ndone", done_cnt - db, 0);
        chk("t6_idle", busy, 0);

        for (int k = 0; k < 10; k++) begin
            delay = $urandom_range(1, 6);
            hold = $urandom_range(0, 4);
            run($sformatf("r%0d", k), int'($urandom & 32'hFFFFFF),
                int'($urandom & 32'hFFF), int'($urandom_range(1, 20)),
                k[0], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
